switch_display_scheduler: RTL and testbench
===========================================

// Module: switch_display_scheduler
//
// PURPOSE
// - Round-robin time-share arbiter for the single-digit 7-segment display.
// - Each switch 0..NUM_REQ-1 that is on is a requester.
// - Each active requester owns the display for DWELL_CYCLES, then the grant
//   rotates to the next active requester. The index of the current owner
//   drives the hex-to-7-seg converter.
// - Replaces the static priority encoder: every raised switch is shown in
//   turn instead of only the highest one.
//
// PARAMETERS
// - NUM_REQ       10          number of requesters, legal range 2..15 (4'hF is reserved for idle)
// - DWELL_CYCLES  50_000_000  display time per grant, in clock cycles (>= 2)
// - GAP_CYCLES    5_000_000   blank time between grants; used only with SCHED_BLANK_GAP_EN
//
// PORTS
// - CLOCK_50_I  in   1        system clock; all flops on the rising edge
// - RESETN_I    in   1        asynchronous, active-low reset
// - REQ_I       in   NUM_REQ  raw switch levels, asynchronous to the clock
// - HOLD_I      in   1        freezes rotation (synchronous, no synchronizer)
// - VALUE_O     out  4        index of the granted requester; 4'hF when idle or blank
// - GRANT_O     out  NUM_REQ  one-hot grant; all zero when idle or blank
// - ACTIVE_O    out  1        high while a grant is held
// - ADVANCE_O   out  1        one-cycle pulse on the first cycle of every new grant
//
// BEHAVIOUR
// - Reset: all outputs are driven to their idle values asynchronously.
//   - VALUE_O = 4'hF, GRANT_O = 0, ACTIVE_O = 0, ADVANCE_O = 0.
//   - State = IDLE, ptr = NUM_REQ-1, dwell counter = 0, synchronizer flops = 0.
// - Input sync: REQ_I passes through two flops to give req_s. Output latency
//   counts from req_s.
// - Search: the winner is the first set bit of req_s, scanning from
//   (ptr+1) mod NUM_REQ upward and wrapping from NUM_REQ-1 to 0.
//   - Implemented combinationally.
//   - The result is registered into VALUE_O, GRANT_O and ptr.
// - FSM states: IDLE, SHOW, and GAP (GAP exists only with the macro).
// - IDLE:
//   - If req_s is nonzero, the next edge moves to SHOW with the search winner.
//   - On that edge: ACTIVE_O = 1, ADVANCE_O = 1, counter = 0.
// - SHOW:
//   - The counter increments every cycle while HOLD_I = 0.
//   - HOLD_I = 1 freezes both the counter and the grant.
//   - Expiry (counter == DWELL_CYCLES-1 and HOLD_I = 0): rearbitrate on the next edge.
//   - Owner drop (req_s[VALUE_O] = 0): rearbitrate on the next edge, even when
//     HOLD_I = 1. This takes priority over expiry in the same cycle.
//   - Rearbitrate, another requester active: load the new winner, counter = 0, ADVANCE_O = 1.
//   - Rearbitrate, the only active requester is the current owner: keep the same
//     VALUE_O, counter = 0, ADVANCE_O = 1.
//   - Rearbitrate, req_s = 0: go to IDLE with idle output values. ptr keeps the last owner.
// - Fairness: a requester that stays active is granted at least once every NUM_REQ
//   grants. New requests are picked up only at rearbitration; there is no preemption.
// - Width: the counter width is $clog2(DWELL_CYCLES) bits, and it never wraps
//   past DWELL_CYCLES-1.
// - All outputs are registered. There is no combinational path from input to output.
//
// CONFIGURATION
// - Macro SCHED_BLANK_GAP_EN.
// - Defined:
//   - Every rearbitration from SHOW goes to GAP first, including the case where
//     the same owner is kept.
//   - In GAP: VALUE_O = 4'hF, GRANT_O = 0, ACTIVE_O = 0. Lasts GAP_CYCLES cycles.
//     HOLD_I is ignored.
//   - At GAP end: search with the current req_s. A winner goes to SHOW with
//     ADVANCE_O = 1. No winner goes to IDLE.
//   - A new request arriving during GAP is eligible at the GAP-end search.
// - Undefined: the GAP state and the GAP_CYCLES logic do not exist. Grants change
//   back-to-back.
//
// TESTING (NUM_REQ=10, DWELL_CYCLES=4, GAP_CYCLES=2 unless noted)
// 1. Reset, then REQ_I = 0:
//    - VALUE_O = F, GRANT_O = 0, ACTIVE_O = 0, forever.
//    - Assert RESETN_I low while in SHOW: outputs are idle immediately, without waiting for a clock edge.
// 2. REQ_I = 10'h005:
//    - VALUE_O sequence 0,0,0,0,2,2,2,2,0,...
//    - ADVANCE_O pulses every 4th cycle.
//    - The first grant appears 3 edges after REQ_I changes.
// 3. REQ_I = 10'h201, then owner 9 drops at dwell count 1:
//    - Next edge: VALUE_O = 0, ADVANCE_O = 1.
//    - Then drop all requests: VALUE_O = 9 -> 0 -> F, ACTIVE_O = 0.
// 4. REQ_I = 10'h010 only:
//    - VALUE_O stays 4, with an ADVANCE_O pulse every 4 cycles.
//    - HOLD_I = 1 for 10 cycles: no ADVANCE_O pulse, and the counter is frozen.
// 5. HOLD_I = 1 while owner 3 drops:
//    - Rearbitration still happens on the next edge.
// 6. With SCHED_BLANK_GAP_EN and REQ_I = 10'h003:
//    - Sequence 0x4, F x2, 1x4, F x2, 0x4, ...
//    - Raise switch 5 during GAP: it is granted at GAP end if it follows ptr in order.

Source files
------------

// File: rtl/switch_display_scheduler.sv
// switch_display_scheduler: round-robin time-share of the 7-seg display among raised switches.
// Define SCHED_BLANK_GAP_EN to insert a blank GAP_CYCLES interval between grants.
module switch_display_scheduler #(
    parameter int NUM_REQ      = 10,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int GAP_CYCLES   = 5_000_000
) (
    input  logic               CLOCK_50_I,
    input  logic               RESETN_I,
    input  logic [NUM_REQ-1:0] REQ_I,
    input  logic               HOLD_I,
    output logic [3:0]         VALUE_O,
    output logic [NUM_REQ-1:0] GRANT_O,
    output logic               ACTIVE_O,
    output logic               ADVANCE_O
);
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
`ifdef SCHED_BLANK_GAP_EN
    localparam logic [1:0] S_GAP = 2'd2;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);
    logic [GW-1:0] gcnt, gcnt_d;
`endif

    if (NUM_REQ < 2 || NUM_REQ > 15 || DWELL_CYCLES < 2 || GAP_CYCLES < 1) begin : g_param_check
        $error("switch_display_scheduler: illegal parameter value");
    end

    logic [NUM_REQ-1:0] req_m, req_s;
    logic [1:0]         state, state_d;
    logic [3:0]         ptr, ptr_d, win, value_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               active_d, adv_d, found, take, blank, rearb, owner_drop;

    // Scan downward so the last hit, i.e. the one closest after ptr, wins.
    always_comb begin
        int j;
        j = 0;
        win = '0;
        found = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(ptr) + i;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if ((req_s & (NUM_REQ'(1) << j)) != '0) begin
                win = 4'(j);
                found = 1'b1;
            end
        end
    end

    // Owner drop overrides HOLD_I and takes priority over dwell expiry.
    assign owner_drop = (req_s & GRANT_O) == '0;
    assign rearb      = owner_drop || (!HOLD_I && cnt == CNT_MAX);

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        cnt_d    = cnt;
        value_d  = VALUE_O;
        grant_d  = GRANT_O;
        active_d = ACTIVE_O;
        adv_d    = 1'b0;
        take     = 1'b0;
        blank    = 1'b0;
`ifdef SCHED_BLANK_GAP_EN
        gcnt_d   = gcnt;
`endif
        case (state)
            S_IDLE: take = found;
            S_SHOW: begin
                if (rearb) begin
`ifdef SCHED_BLANK_GAP_EN
                    state_d = S_GAP;
                    gcnt_d  = '0;
                    cnt_d   = '0;
                    blank   = 1'b1;
`else
                    state_d = S_IDLE;
                    take    = found;
                    blank   = !found;
`endif
                end else begin
                    cnt_d = HOLD_I ? cnt : cnt + 1'b1;
                end
            end
`ifdef SCHED_BLANK_GAP_EN
            S_GAP: begin
                gcnt_d = gcnt + 1'b1;
                if (gcnt == GAP_MAX) begin
                    state_d = S_IDLE;
                    take    = found;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                blank   = 1'b1;
            end
        endcase
        if (take) begin
            state_d  = S_SHOW;
            ptr_d    = win;
            value_d  = win;
            grant_d  = NUM_REQ'(1) << win;
            active_d = 1'b1;
            adv_d    = 1'b1;
            cnt_d    = '0;
        end
        if (blank) begin
            value_d  = 4'hF;
            grant_d  = '0;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            req_m     <= '0;
            req_s     <= '0;
            state     <= S_IDLE;
            ptr       <= 4'(NUM_REQ - 1);
            cnt       <= '0;
            VALUE_O   <= 4'hF;
            GRANT_O   <= '0;
            ACTIVE_O  <= 1'b0;
            ADVANCE_O <= 1'b0;
`ifdef SCHED_BLANK_GAP_EN
            gcnt      <= '0;
`endif
        end else begin
            req_m     <= REQ_I;
            req_s     <= req_m;
            state     <= state_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            VALUE_O   <= value_d;
            GRANT_O   <= grant_d;
            ACTIVE_O  <= active_d;
            ADVANCE_O <= adv_d;
`ifdef SCHED_BLANK_GAP_EN
            gcnt      <= gcnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_switch_display_scheduler.sv
// tb_switch_display_scheduler: directed table plus hand sequences for the display scheduler.
module tb_switch_display_scheduler;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         hold = 1'b0;
    logic [N-1:0] req = '0;
    logic [3:0]   value;
    logic [N-1:0] grant;
    logic         active, advance;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         hold;
        logic [3:0]   val;
        logic         act;
        logic         adv;
    } vec_t;
    vec_t tbl[$];

    switch_display_scheduler #(.NUM_REQ(N), .DWELL_CYCLES(4), .GAP_CYCLES(2)) dut (
        .CLOCK_50_I(clk),
        .RESETN_I(rst_n),
        .REQ_I(req),
        .HOLD_I(hold),
        .VALUE_O(value),
        .GRANT_O(grant),
        .ACTIVE_O(active),
        .ADVANCE_O(advance)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Packed as {value, grant, active, advance}; grant is derived from the expected index.
    task automatic expect_out(input string name, input logic [3:0] v, input logic a, input logic d);
        logic [N-1:0]  g;
        logic [N+5:0]  got, exp;
        g   = (v == 4'hF) ? '0 : N'(1) << v;
        exp = {v, g, a, d};
        got = {value, grant, active, advance};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got value=%0h grant=%03h active=%0b adv=%0b required value=%0h grant=%03h active=%0b adv=%0b",
                     name, value, grant, active, advance, v, g, a, d);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;
        step();
        step();
        expect_out("reset", 4'hF, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic [N-1:0] r, input logic h, input logic [3:0] v,
                                input logic a, input logic d);
        vec_t e;
        e.req  = r;
        e.hold = h;
        e.val  = v;
        e.act  = a;
        e.adv  = d;
        tbl.push_back(e);
    endfunction

    initial begin
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            expect_out("idle", 4'hF, 1'b0, 1'b0);
        end

        // Switches 0 and 2 alternate; first grant lands three edges after REQ_I changes.
        add(10'h005, 0, 4'hF, 0, 0);
        add(10'h005, 0, 4'hF, 0, 0);
        add(10'h005, 0, 4'h0, 1, 1);
        for (int i = 0; i < 3; i++) add(10'h005, 0, 4'h0, 1, 0);
`ifdef SCHED_BLANK_GAP_EN
        for (int i = 0; i < 2; i++) add(10'h005, 0, 4'hF, 0, 0);
        add(10'h005, 0, 4'h2, 1, 1);
        for (int i = 0; i < 3; i++) add(10'h005, 0, 4'h2, 1, 0);
        for (int i = 0; i < 2; i++) add(10'h005, 0, 4'hF, 0, 0);
        add(10'h005, 0, 4'h0, 1, 1);
`else
        add(10'h005, 0, 4'h2, 1, 1);
        for (int i = 0; i < 3; i++) add(10'h005, 0, 4'h2, 1, 0);
        add(10'h005, 0, 4'h0, 1, 1);
        for (int i = 0; i < 3; i++) add(10'h005, 0, 4'h0, 1, 0);
        add(10'h005, 0, 4'h2, 1, 1);
`endif
        foreach (tbl[k]) begin
            req  = tbl[k].req;
            hold = tbl[k].hold;
            step();
            expect_out($sformatf("tbl%0d", k), tbl[k].val, tbl[k].act, tbl[k].adv);
        end

        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", 4'hF, 1'b0, 1'b0);
        do_reset();

`ifdef SCHED_BLANK_GAP_EN
        req = 10'h003;
        step(); step(); step();
        expect_out("g_own0", 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin step(); expect_out("g_own0_dwell", 4'h0, 1'b1, 1'b0); end
        for (int i = 0; i < 2; i++) begin step(); expect_out("g_gap_a", 4'hF, 1'b0, 1'b0); end
        step(); expect_out("g_own1", 4'h1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin step(); expect_out("g_own1_dwell", 4'h1, 1'b1, 1'b0); end
        req = 10'h023;
        for (int i = 0; i < 2; i++) begin step(); expect_out("g_gap_b", 4'hF, 1'b0, 1'b0); end
        step(); expect_out("g_new5", 4'h5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin step(); expect_out("g_own5_dwell", 4'h5, 1'b1, 1'b0); end
        for (int i = 0; i < 2; i++) begin step(); expect_out("g_gap_c", 4'hF, 1'b0, 1'b0); end
        step(); expect_out("g_wrap0", 4'h0, 1'b1, 1'b1);
`else
        // Owner 9 loses its request in req_s while the dwell count is 1.
        req = 10'h201;
        step(); step(); step();
        expect_out("t3_own0", 4'h0, 1'b1, 1'b1);
        step(); step(); step();
        expect_out("t3_own0_end", 4'h0, 1'b1, 1'b0);
        req = 10'h001;
        step(); expect_out("t3_own9", 4'h9, 1'b1, 1'b1);
        step(); expect_out("t3_own9_c1", 4'h9, 1'b1, 1'b0);
        step(); expect_out("t3_drop9", 4'h0, 1'b1, 1'b1);
        req = '0;
        step(); expect_out("t3_tail_a", 4'h0, 1'b1, 1'b0);
        step(); expect_out("t3_tail_b", 4'h0, 1'b1, 1'b0);
        step(); expect_out("t3_to_idle", 4'hF, 1'b0, 1'b0);
        step(); expect_out("t3_stay_idle", 4'hF, 1'b0, 1'b0);

        do_reset();
        req = 10'h010;
        step(); step(); step();
        expect_out("t4_own4", 4'h4, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin step(); expect_out("t4_dwell", 4'h4, 1'b1, 1'b0); end
        step(); expect_out("t4_regrant", 4'h4, 1'b1, 1'b1);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin step(); expect_out("t4_hold", 4'h4, 1'b1, 1'b0); end
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); expect_out("t4_resume", 4'h4, 1'b1, 1'b0); end
        step(); expect_out("t4_resume_adv", 4'h4, 1'b1, 1'b1);

        do_reset();
        req = 10'h048;
        step(); step(); step();
        expect_out("t5_own3", 4'h3, 1'b1, 1'b1);
        hold = 1'b1;
        req  = 10'h040;
        step(); expect_out("t5_sync_a", 4'h3, 1'b1, 1'b0);
        step(); expect_out("t5_sync_b", 4'h3, 1'b1, 1'b0);
        step(); expect_out("t5_drop_held", 4'h6, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin step(); expect_out("t5_held6", 4'h6, 1'b1, 1'b0); end
        hold = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
